// File: rtl/cyclic_bram_stream.sv
// Cyclic re-read buffer: one wide fill over a stream port, then replay of a read window (repeats+1) times.
// Define CYCLIC_BRAM_PINGPONG_EN for two-bank operation (fill one bank while the other is replayed).
module cyclic_bram_stream #(
    parameter int R_DEPTH      = 256,
    parameter int R_DATA_WIDTH = 16,
    parameter int W_DATA_WIDTH = 64,
    parameter int LATENCY      = 2,
    parameter int REP_WIDTH    = 8,
    localparam int K   = W_DATA_WIDTH / R_DATA_WIDTH,
    localparam int RAW = $clog2(R_DEPTH),
    localparam int WAW = $clog2(R_DEPTH / K)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clken,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [W_DATA_WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [R_DATA_WIDTH-1:0] m_data,
    output logic                    m_last,
    input  logic [WAW-1:0]          cfg_w_addr_max,
    input  logic [RAW-1:0]          cfg_r_addr_min,
    input  logic [RAW-1:0]          cfg_r_addr_max,
    input  logic [REP_WIDTH-1:0]    cfg_repeats,
    output logic                    busy
);
`ifdef CYCLIC_BRAM_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int MAW = $clog2(NB * R_DEPTH);
    localparam int KW  = $clog2(K);
    localparam int D   = LATENCY + 1;
    localparam int PW  = $clog2(D);
    localparam int CW  = $clog2(D + 1);

    logic [R_DATA_WIDTH-1:0] mem [NB*R_DEPTH];
    logic [R_DATA_WIDTH-1:0] dpipe [1:LATENCY];
    logic [R_DATA_WIDTH-1:0] fdata [D];
    logic [D-1:0]            flast;
    logic [LATENCY:1]        vld_pipe, lst_pipe;
    logic [PW-1:0]           wptr, rptr;
    logic [CW-1:0]           fcnt;

    logic [WAW-1:0]       w_addr;
    logic [RAW-1:0]       r_addr, r_min, r_max, r_end, st_min, st_max;
    logic [REP_WIDTH-1:0] pass, reps, st_reps;
    logic [MAW-1:0]       wbase, raddr_m;
    logic                 reading, wb, rb, start;
    logic                 acc, fill_last, issue, issue_last, pop;

    assign acc        = clken && s_valid && s_ready;
    assign fill_last  = acc && (s_last || w_addr == cfg_w_addr_max);
    assign r_end      = (r_min > r_max) ? r_min : r_max;
    assign pop        = m_valid && m_ready;
    // Credits: a new read may start only if its beat is guaranteed a FIFO slot.
    assign issue      = clken && reading &&
                        (int'($countones(vld_pipe)) + int'(fcnt) - int'(pop) < D);
    assign issue_last = issue && r_addr == r_end && pass == reps;
    assign m_valid    = fcnt != '0;
    assign m_data     = fdata[rptr];
    assign m_last     = m_valid && flast[rptr];
    assign wbase      = (MAW'(w_addr) << KW) | (wb ? MAW'(R_DEPTH) : MAW'(0));
    assign raddr_m    = MAW'(r_addr) | (rb ? MAW'(R_DEPTH) : MAW'(0));

    always_ff @(posedge clk) begin
        if (acc)
            for (int j = 0; j < K; j++)
                mem[wbase | MAW'(j)] <= s_data[j*R_DATA_WIDTH +: R_DATA_WIDTH];
        if (clken) begin
            dpipe[1] <= mem[raddr_m];
            for (int i = 2; i <= LATENCY; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
            wptr     <= '0;
            rptr     <= '0;
            fcnt     <= '0;
            flast    <= '0;
            for (int i = 0; i < D; i++) fdata[i] <= '0;
        end else if (clken) begin
            vld_pipe[1] <= issue;
            lst_pipe[1] <= issue_last;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                lst_pipe[i] <= lst_pipe[i-1];
            end
            if (vld_pipe[LATENCY]) begin
                fdata[wptr] <= dpipe[LATENCY];
                flast[wptr] <= lst_pipe[LATENCY];
                wptr        <= (wptr == PW'(D - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) rptr <= (rptr == PW'(D - 1)) ? '0 : rptr + 1'b1;
            fcnt <= fcnt + CW'(vld_pipe[LATENCY]) - CW'(pop);
        end
    end

    // Write pointer and read-address sequencer; a start overrides the last issue step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_addr  <= '0;
            r_addr  <= '0;
            r_min   <= '0;
            r_max   <= '0;
            reps    <= '0;
            pass    <= '0;
            reading <= 1'b0;
        end else if (clken) begin
            if (acc) w_addr <= fill_last ? '0 : w_addr + 1'b1;
            if (issue) begin
                if (r_addr == r_end) begin
                    r_addr <= r_min;
                    if (pass == reps) reading <= 1'b0;
                    else              pass    <= pass + 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
            if (start) begin
                reading <= 1'b1;
                r_min   <= st_min;
                r_max   <= st_max;
                reps    <= st_reps;
                r_addr  <= st_min;
                pass    <= '0;
            end
        end
    end

`ifdef CYCLIC_BRAM_PINGPONG_EN
    logic                 wfull;
    logic [RAW-1:0]       p_min, p_max;
    logic [REP_WIDTH-1:0] p_reps;

    assign s_ready = resetn && !wfull;
    assign start   = (fill_last || wfull) && (!reading || issue_last);
    assign st_min  = wfull ? p_min  : cfg_r_addr_min;
    assign st_max  = wfull ? p_max  : cfg_r_addr_max;
    assign st_reps = wfull ? p_reps : cfg_repeats;
    assign busy    = reading || wfull || m_valid || (|vld_pipe) || w_addr != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb     <= 1'b0;
            rb     <= 1'b0;
            wfull  <= 1'b0;
            p_min  <= '0;
            p_max  <= '0;
            p_reps <= '0;
        end else if (clken) begin
            if (fill_last && !start) begin
                wfull  <= 1'b1;
                p_min  <= cfg_r_addr_min;
                p_max  <= cfg_r_addr_max;
                p_reps <= cfg_repeats;
            end
            if (start) begin
                rb    <= wb;
                wb    <= !wb;
                wfull <= 1'b0;
            end
        end
    end
`else
    typedef enum logic {S_FILL, S_READ} state_t;
    state_t state;

    assign wb      = 1'b0;
    assign rb      = 1'b0;
    assign s_ready = resetn && state == S_FILL;
    assign start   = fill_last;
    assign st_min  = cfg_r_addr_min;
    assign st_max  = cfg_r_addr_max;
    assign st_reps = cfg_repeats;
    assign busy    = state != S_FILL || w_addr != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                state <= S_FILL;
        else if (clken) begin
            if (fill_last)          state <= S_READ;
            else if (pop && m_last) state <= S_FILL;
        end
    end
`endif

endmodule
